rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single datapath resource (for example, the `example` unit) among `N` requesters. It grants exclusive ownership to one requester at a time and holds the grant until that owner reports completion or withdraws. It then inserts one idle release cycle and rotates priority. It sits between the requesting blocks and the shared unit, and its grant vector drives the unit's input muxing.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/rr_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// +----------------------------------------------------------------------------+
// | arb_pkg : shared types and helpers for the round-robin arbiter             |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Index width for n entries; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------------+
// | rr_pick : combinational rotate-priority picker, scans upward from ptr_i    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]        req_i,
  input  logic [idx_w(N)-1:0] ptr_i,
  output logic [N-1:0]        pick_o,
  output logic [idx_w(N)-1:0] idx_o,
  output logic                any_o
);

  localparam int IDW = idx_w(N);

  logic [IDW:0]   sum;
  logic [IDW-1:0] j;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum    = '0;
    j      = '0;
    // ptr_i < N and i < N, so one conditional subtract performs the wrap.
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      j = sum[IDW-1:0];
      if (!any_o && req_i[j]) begin
        any_o     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : round-robin ownership arbiter with one idle release cycle.    |
// | Optional hold limit enabled by defining ARB_HOLD_LIMIT_EN.                 |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                done,
  output logic [N-1:0]        gnt,
  output logic                gnt_valid,
  output logic [idx_w(N)-1:0] gnt_id,
  output logic                busy,
  output logic                preempt
);

  localparam int IDW = idx_w(N);

  if (N < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_arbiter: N must be >= 2 and MAX_HOLD >= 1");
  end

  arb_state_t     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           busy_q, busy_d;
  logic           preempt_q, preempt_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           hold_hit;

  rr_pick #(.N(N)) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = idx_w(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Counter reads k-1 on the k-th GRANT edge, so the grant spans MAX_HOLD cycles.
  assign hold_hit = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if (state_q == GRANT) hold_d = hold_q + HOLD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = GRANT;
          gnt_d    = pick;
          gnt_id_d = pick_idx;
        end
      end
      GRANT: begin
        if (done || !req[gnt_id_q] || hold_hit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          ptr_d     = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
          preempt_d = hold_hit && !done && req[gnt_id_q];
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
    gnt_valid_d = |gnt_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign preempt   = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_rr_arbiter : directed self-checking bench for rr_arbiter (N=3)          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int n_tests = 0;
  int n_fail  = 0;

  // Packed view: {gnt[2:0], gnt_valid, gnt_id[1:0], busy, preempt}
  logic [7:0] obs;
  assign obs = {gnt, gnt_valid, gnt_id, busy, preempt};

  rr_arbiter #(.N(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 3'b000;
    done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (obs !== 8'b000_0_00_0_0) begin
      n_fail++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 8'b000_0_00_0_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    logic [7:0] e;
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      int own;
      own = k % 3;
      e = {3'(1 << own), 1'b1, 2'(own), 1'b1, 1'b0};
      tick();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rot_grant%0d_c1 obs=%b exp=%b", k, obs, e);
      end
      tick();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rot_grant%0d_c2 obs=%b exp=%b", k, obs, e);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_tests++;
      if (obs !== 8'b000_0_00_1_0) begin
        n_fail++;
        $display("FAIL rot_release%0d obs=%b exp=%b", k, obs, 8'b000_0_00_1_0);
      end
      tick();
      n_tests++;
      if (obs !== 8'b000_0_00_0_0) begin
        n_fail++;
        $display("FAIL rot_idle%0d obs=%b exp=%b", k, obs, 8'b000_0_00_0_0);
      end
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 3'b100;
    tick();
    n_tests++;
    if (obs !== 8'b100_1_10_1_0) begin
      n_fail++;
      $display("FAIL wrap_grant2 obs=%b exp=%b", obs, 8'b100_1_10_1_0);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 3'b101;
    tick();
    n_tests++;
    if (obs !== 8'b000_0_00_0_0) begin
      n_fail++;
      $display("FAIL wrap_idle obs=%b exp=%b", obs, 8'b000_0_00_0_0);
    end
    tick();
    n_tests++;
    if (obs !== 8'b001_1_00_1_0) begin
      n_fail++;
      $display("FAIL wrap_grant0 obs=%b exp=%b", obs, 8'b001_1_00_1_0);
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_simul_release();
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b111;
    n_tests++;
    if (obs !== 8'b010_1_01_1_0) begin
      n_fail++;
      $display("FAIL simul_grant1 obs=%b exp=%b", obs, 8'b010_1_01_1_0);
    end
    done = 1'b1;
    req  = 3'b101;
    tick();
    done = 1'b0;
    n_tests++;
    if (obs !== 8'b000_0_00_1_0) begin
      n_fail++;
      $display("FAIL simul_release obs=%b exp=%b", obs, 8'b000_0_00_1_0);
    end
    tick();
    n_tests++;
    if (obs !== 8'b000_0_00_0_0) begin
      n_fail++;
      $display("FAIL simul_single_release obs=%b exp=%b", obs, 8'b000_0_00_0_0);
    end
    tick();
    n_tests++;
    if (obs !== 8'b100_1_10_1_0) begin
      n_fail++;
      $display("FAIL simul_ptr2_pick obs=%b exp=%b", obs, 8'b100_1_10_1_0);
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_hold_limit();
    do_reset();
    req = 3'b001;
    tick();
`ifdef ARB_HOLD_LIMIT_EN
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (obs !== 8'b001_1_00_1_0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d obs=%b exp=%b", c, obs, 8'b001_1_00_1_0);
      end
      tick();
    end
    n_tests++;
    if (obs !== 8'b000_0_00_1_1) begin
      n_fail++;
      $display("FAIL hold_preempt obs=%b exp=%b", obs, 8'b000_0_00_1_1);
    end
    tick();
    n_tests++;
    if (obs !== 8'b000_0_00_0_0) begin
      n_fail++;
      $display("FAIL hold_idle obs=%b exp=%b", obs, 8'b000_0_00_0_0);
    end
    tick();
    n_tests++;
    if (obs !== 8'b001_1_00_1_0) begin
      n_fail++;
      $display("FAIL hold_regrant obs=%b exp=%b", obs, 8'b001_1_00_1_0);
    end
`else
    for (int c = 0; c < 55; c++) begin
      n_tests++;
      if (obs !== 8'b001_1_00_1_0) begin
        n_fail++;
        $display("FAIL hold_forever%0d obs=%b exp=%b", c, obs, 8'b001_1_00_1_0);
      end
      tick();
    end
`endif
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b010;
    tick();
    n_tests++;
    if (obs !== 8'b010_1_01_1_0) begin
      n_fail++;
      $display("FAIL areset_pregrant obs=%b exp=%b", obs, 8'b010_1_01_1_0);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== 8'b000_0_00_0_0) begin
      n_fail++;
      $display("FAIL areset_immediate obs=%b exp=%b", obs, 8'b000_0_00_0_0);
    end
    req = 3'b110;
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs !== 8'b010_1_01_1_0) begin
      n_fail++;
      $display("FAIL areset_first_owner obs=%b exp=%b", obs, 8'b010_1_01_1_0);
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_done_idle();
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_tests++;
    if (obs !== 8'b000_0_00_0_0) begin
      n_fail++;
      $display("FAIL done_idle_c1 obs=%b exp=%b", obs, 8'b000_0_00_0_0);
    end
    tick();
    n_tests++;
    if (obs !== 8'b000_0_00_0_0) begin
      n_fail++;
      $display("FAIL done_idle_c2 obs=%b exp=%b", obs, 8'b000_0_00_0_0);
    end
    req = 3'b001;
    tick();
    n_tests++;
    if (obs !== 8'b001_1_00_1_0) begin
      n_fail++;
      $display("FAIL done_idle_grant obs=%b exp=%b", obs, 8'b001_1_00_1_0);
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_simul_release();
    test_hold_limit();
    test_async_reset();
    test_done_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
